// File: rtl/clk_div_arbiter.sv
// Round-robin owner of the shared clock divider's COUNT input; the grantee is held
// off until the divider has run one full output period at the newly loaded value.
module clk_div_arbiter #(
   parameter int                     NUM_REQ     = 4,
   parameter int                     COUNT_WIDTH = 32,
   parameter logic [COUNT_WIDTH-1:0] RESET_COUNT = '0
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [NUM_REQ-1:0]             i_req,
   input  logic [NUM_REQ*COUNT_WIDTH-1:0] i_count_req,
   output logic [NUM_REQ-1:0]             o_grant,
   output logic                           o_ready,
   output logic [COUNT_WIDTH-1:0]         o_count,
   output logic                           o_busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int SET_W = COUNT_WIDTH + 2;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_LOAD   = 2'd1;
   localparam logic [1:0] ST_SETTLE = 2'd2;
   localparam logic [1:0] ST_OWNED  = 2'd3;

   localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

   logic [1:0]             state_r;
   logic [IDX_W-1:0]       last_r;
   logic [IDX_W-1:0]       gnt_idx_r;
   logic [NUM_REQ-1:0]     grant_r;
   logic                   ready_r;
   logic                   busy_r;
   logic [COUNT_WIDTH-1:0] count_r;
   logic [COUNT_WIDTH-1:0] cnt_next_r;
   logic [SET_W-1:0]       settle_cnt_r;

   logic                   win_found_s;
   logic [IDX_W-1:0]       win_idx_s;
   logic [COUNT_WIDTH-1:0] win_count_s;
   logic                   grantee_req_s;
   logic [SET_W-1:0]       settle_load_s;
   logic [COUNT_WIDTH-1:0] count_arr_s [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign count_arr_s[g] = i_count_req[g*COUNT_WIDTH +: COUNT_WIDTH];
   end

   // Round-robin search: first requester strictly after the last winner, with wrap.
   always_comb begin : arb_search
      int idx_s;
      win_found_s = 1'b0;
      win_idx_s   = '0;
      idx_s       = 0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx_s = (int'(last_r) + i) % NUM_REQ;
         if (!win_found_s && i_req[IDX_W'(idx_s)]) begin
            win_found_s = 1'b1;
            win_idx_s   = IDX_W'(idx_s);
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Winner's divide value, the grantee's live request level and the settle reload.
   always_comb begin
      win_count_s   = count_arr_s[win_idx_s];
      grantee_req_s = i_req[gnt_idx_r];
      // 2*(cnt+1)-1 evaluated two bits wider so an all-ones count cannot wrap.
      settle_load_s = ((SET_W'(cnt_next_r) + SET_W'(1)) << 1) - SET_W'(1);
   end

   // Ownership FSM; every output is a register updated here.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= ST_IDLE;
         last_r       <= LAST_RESET;
         gnt_idx_r    <= '0;
         grant_r      <= '0;
         ready_r      <= 1'b0;
         busy_r       <= 1'b0;
         count_r      <= RESET_COUNT;
         cnt_next_r   <= RESET_COUNT;
         settle_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (win_found_s) begin
                  grant_r    <= NUM_REQ'(1) << win_idx_s;
                  gnt_idx_r  <= win_idx_s;
                  last_r     <= win_idx_s;
                  cnt_next_r <= win_count_s;
                  busy_r     <= 1'b1;
                  state_r    <= ST_LOAD;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               count_r <= cnt_next_r;
               if (cnt_next_r == count_r) begin
                  ready_r <= 1'b1;
                  state_r <= ST_OWNED;
               end else begin
                  settle_cnt_r <= settle_load_s;
                  state_r      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               // A release wins over a counter that happens to expire on the same edge.
               if (!grantee_req_s) begin
                  grant_r <= '0;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else if (settle_cnt_r == SET_W'(0)) begin
                  ready_r <= 1'b1;
                  state_r <= ST_OWNED;
               end else begin
                  settle_cnt_r <= settle_cnt_r - SET_W'(1);
               end
            end
            ST_OWNED: begin
               if (!grantee_req_s) begin
                  grant_r <= '0;
                  ready_r <= 1'b0;
                  busy_r  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_OWNED;
               end
            end
            default: begin
               grant_r <= '0;
               ready_r <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_grant = grant_r;
   assign o_ready = ready_r;
   assign o_count = count_r;
   assign o_busy  = busy_r;

endmodule

// File: tb/tb_clk_div_arbiter.sv
// Directed bench for clk_div_arbiter: a cycle-by-cycle vector table plus
// hand-written sequences for round-robin, abort, wide-count and async reset.
module tb_clk_div_arbiter;

   localparam int NR = 4;
   localparam int CW = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req;
   logic [NR*CW-1:0] cr;
   logic [NR-1:0]   grant;
   logic            ready;
   logic [CW-1:0]   count;
   logic            busy;

   always #5 clk = ~clk;

   clk_div_arbiter #(.NUM_REQ(NR), .COUNT_WIDTH(CW), .RESET_COUNT(32'd0)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req       (req),
      .i_count_req (cr),
      .o_grant     (grant),
      .o_ready     (ready),
      .o_count     (count),
      .o_busy      (busy)
   );

   typedef struct {
      logic [NR-1:0]    req;
      logic [NR*CW-1:0] cr;
      logic [NR-1:0]    grant;
      logic             ready;
      logic [CW-1:0]    count;
      logic             busy;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NR*CW-1:0] pack4(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                               input logic [CW-1:0] c2, input logic [CW-1:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   task automatic add(input logic [NR-1:0] r, input logic [NR*CW-1:0] c, input logic [NR-1:0] g,
                      input logic rd, input logic [CW-1:0] cnt, input logic b);
      vec_t v;
      v.req = r; v.cr = c; v.grant = g; v.ready = rd; v.count = cnt; v.busy = b;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req   = '0;
      cr    = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [NR*CW-1:0] cr_a, cr_b, cr_c;
      logic [CW-1:0]    cnts [NR];
      logic [CW-1:0]    prev;
      int               order [5];
      int               lat, exp_lat, who;
      logic             seen_ready;

      // Single requester 0, count 3: S = 8, ready after edge k+S+1 = 10.
      cr_a = pack4(32'd3, 32'd0, 32'd0, 32'd0);
      add(4'b0001, cr_a, 4'b0001, 1'b0, 32'd0, 1'b1);
      add(4'b0001, cr_a, 4'b0001, 1'b0, 32'd3, 1'b1);
      for (int i = 0; i < 7; i++) add(4'b0001, cr_a, 4'b0001, 1'b0, 32'd3, 1'b1);
      add(4'b0001, cr_a, 4'b0001, 1'b1, 32'd3, 1'b1);
      add(4'b0001, cr_a, 4'b0001, 1'b1, 32'd3, 1'b1);
      add(4'b0000, cr_a, 4'b0000, 1'b0, 32'd3, 1'b0);
      // Requester 2 asks for the count already loaded, then changes it while owning.
      cr_b = pack4(32'd0, 32'd0, 32'd3, 32'd0);
      cr_c = pack4(32'd0, 32'd0, 32'd9, 32'd0);
      add(4'b0100, cr_b, 4'b0100, 1'b0, 32'd3, 1'b1);
      add(4'b0100, cr_b, 4'b0100, 1'b1, 32'd3, 1'b1);
      add(4'b0100, cr_c, 4'b0100, 1'b1, 32'd3, 1'b1);
      add(4'b0100, cr_c, 4'b0100, 1'b1, 32'd3, 1'b1);
      add(4'b0000, cr_c, 4'b0000, 1'b0, 32'd3, 1'b0);

      rst_n = 1'b0;
      req   = '0;
      cr    = '0;
      @(negedge clk);
      @(negedge clk);
      check("reset grant", 64'(grant), 64'd0);
      check("reset ready", 64'(ready), 64'd0);
      check("reset busy",  64'(busy),  64'd0);
      check("reset count", 64'(count), 64'd0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         req = vecs[i].req;
         cr  = vecs[i].cr;
         step();
         check($sformatf("vec%0d grant", i), 64'(grant), 64'(vecs[i].grant));
         check($sformatf("vec%0d ready", i), 64'(ready), 64'(vecs[i].ready));
         check($sformatf("vec%0d count", i), 64'(count), 64'(vecs[i].count));
         check($sformatf("vec%0d busy",  i), 64'(busy),  64'(vecs[i].busy));
      end

      // Round robin with all four requesting; each releases two cycles after ready.
      do_reset();
      cnts[0] = 32'd2; cnts[1] = 32'd2; cnts[2] = 32'd1; cnts[3] = 32'd0;
      cr    = pack4(cnts[0], cnts[1], cnts[2], cnts[3]);
      order = '{0, 1, 2, 3, 0};
      prev  = 32'd0;
      req   = 4'b1111;
      step();
      for (int g = 0; g < 5; g++) begin
         who = order[g];
         check($sformatf("rr%0d grant", g), 64'(grant), 64'(4'b0001 << who));
         check($sformatf("rr%0d busy", g), 64'(busy), 64'd1);
         exp_lat = (cnts[who] == prev) ? 1 : 2 * (int'(cnts[who]) + 1) + 1;
         lat = 0;
         while (!ready && lat < 200) begin
            step();
            lat++;
         end
         check($sformatf("rr%0d ready latency", g), 64'(lat), 64'(exp_lat));
         check($sformatf("rr%0d count", g), 64'(count), 64'(cnts[who]));
         prev = cnts[who];
         step();
         step();
         req[who] = 1'b0;
         step();
         check($sformatf("rr%0d idle grant", g), 64'(grant), 64'd0);
         check($sformatf("rr%0d idle ready", g), 64'(ready), 64'd0);
         check($sformatf("rr%0d idle busy", g), 64'(busy), 64'd0);
         if (g < 4) begin
            req[who] = 1'b1;
            step();
         end
      end

      // Grantee 1 (count 100) aborts mid-settle; pointer then favours requester 2.
      do_reset();
      cr  = pack4(32'd0, 32'd100, 32'd0, 32'd0);
      req = 4'b0010;
      step();
      check("abort grant", 64'(grant), 64'(4'b0010));
      seen_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         seen_ready = seen_ready | ready;
      end
      check("abort ready never", 64'(seen_ready), 64'd0);
      check("abort count loaded", 64'(count), 64'd100);
      req = 4'b0000;
      step();
      check("abort grant cleared", 64'(grant), 64'd0);
      check("abort busy cleared", 64'(busy), 64'd0);
      check("abort ready", 64'(ready), 64'd0);
      check("abort count kept", 64'(count), 64'd100);
      req = 4'b0101;
      step();
      check("abort next winner", 64'(grant), 64'(4'b0100));
      req = 4'b0000;

      // All-ones count must load 2^33-1 into the settle counter without wrapping.
      do_reset();
      cr  = pack4(32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF);
      req = 4'b1000;
      step();
      check("wide grant", 64'(grant), 64'(4'b1000));
      step();
      check("wide count", 64'(count), 64'h0000_0000_FFFF_FFFF);
      check("wide settle load", 64'(dut.settle_cnt_r), 64'h0000_0001_FFFF_FFFF);
      repeat (5) step();
      check("wide settle dec", 64'(dut.settle_cnt_r), 64'h0000_0001_FFFF_FFFA);
      check("wide ready", 64'(ready), 64'd0);
      check("wide busy", 64'(busy), 64'd1);

      // Asynchronous reset between edges while OWNED.
      do_reset();
      cr  = pack4(32'd7, 32'd0, 32'd0, 32'd0);
      req = 4'b0001;
      lat = 0;
      while (!ready && lat < 100) begin
         step();
         lat++;
      end
      check("areset pre ready", 64'(ready), 64'd1);
      check("areset pre count", 64'(count), 64'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check("areset grant", 64'(grant), 64'd0);
      check("areset ready", 64'(ready), 64'd0);
      check("areset busy", 64'(busy), 64'd0);
      check("areset count", 64'(count), 64'd0);
      @(negedge clk);
      req = '0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
